// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller for the 8-bit ALU. It accepts one op at a time,
// runs POW as a square-and-multiply loop, and holds the result until a consumer takes it.
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, POW, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] op_r;
    logic [WIDTH-1:0] a_r, b_r, acc, base, e, e_nx, acc_nx, alu_res;
    logic base_ovf, pow_ovf, alu_ovf, step_ovf;
    logic [WIDTH:0] sum, diff;
    logic [2*WIDTH-1:0] prod, sq, pr;
    assign sum  = {1'b0, a_r} + {1'b0, b_r};
    assign diff = {1'b0, a_r} - {1'b0, b_r};
    assign prod = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
    assign sq   = {{WIDTH{1'b0}}, base} * {{WIDTH{1'b0}}, base};
    assign pr   = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, base};
    assign e_nx = e >> 1;
    assign acc_nx = e[0] ? pr[WIDTH-1:0] : acc;
    assign step_ovf = e[0] && acc != '0 && (base_ovf || pr[2*WIDTH-1:WIDTH] != '0);
    assign start_ready = state == IDLE;
    assign res_valid = state == DONE;
    assign busy = state != IDLE;
    always_comb begin
        alu_res = a_r;
        alu_ovf = 1'b0;
        case (op_r)
            3'd0: begin alu_res = sum[WIDTH-1:0]; alu_ovf = sum[WIDTH]; end
            3'd1: begin alu_res = diff[WIDTH-1:0]; alu_ovf = diff[WIDTH]; end
            3'd2: alu_res = a_r & b_r;
            3'd3: alu_res = a_r | b_r;
            3'd4: alu_res = a_r ^ b_r;
            3'd5: begin alu_res = prod[WIDTH-1:0]; alu_ovf = prod[2*WIDTH-1:WIDTH] != '0; end
            3'd6: alu_res = WIDTH'(1);
            default: ;
        endcase
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = start_valid ? EXEC : IDLE;
            EXEC: state_nx = POW;
            POW:  state_nx = e_nx == '0 ? DONE : POW;
            DONE: state_nx = res_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // Every op passes through POW; non-POW ops and b=0 load e=0 so the loop
    // retires after one pass with acc already holding the answer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r <= '0;
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            base <= '0;
            e <= '0;
            base_ovf <= 1'b0;
            pow_ovf <= 1'b0;
            result <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    op_r <= op;
                    a_r <= a;
                    b_r <= b;
                end
                EXEC: begin
                    acc <= alu_res;
                    base <= a_r;
                    e <= op_r == 3'd6 ? b_r : '0;
                    base_ovf <= 1'b0;
                    pow_ovf <= alu_ovf;
                end
                POW: begin
                    acc <= acc_nx;
                    base <= sq[WIDTH-1:0];
                    e <= e_nx;
                    base_ovf <= base_ovf | (sq[2*WIDTH-1:WIDTH] != '0 && e_nx != '0);
                    pow_ovf <= pow_ovf | step_ovf;
                    if (e_nx == '0) begin
                        result <= acc_nx;
                        overflow <= pow_ovf | step_ovf;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with directed and random ops
// checked against an arithmetic reference model.
module tb_alu_sequencer;
    logic clk = 0, rst = 1, start_valid = 0, res_ready = 1;
    logic [2:0] op = 0;
    logic [7:0] a = 0, b = 0;
    logic start_ready, res_valid, overflow, busy;
    logic [7:0] result;

    alu_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .a(a), .b(b), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic o;
        int lat;
        int k;
    } exp_t;
    exp_t q[$];
    int errors = 0, checks = 0, cyc = 0, last_hs = -10;
    bit rr_rand = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Latency counts edges from the accept edge to DONE entry.
    function automatic void model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] r, output logic ov, output int lat);
        int t, big;
        logic [7:0] lo;
        ov = 0;
        lat = 2;
        r = x;
        case (o)
            3'd0: begin t = int'(x) + int'(y); r = t[7:0]; ov = t > 255; end
            3'd1: begin t = int'(x) - int'(y); r = t[7:0]; ov = t < 0; end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: begin t = int'(x) * int'(y); r = t[7:0]; ov = t > 255; end
            3'd6: begin
                lo = 8'd1;
                big = 1;
                for (int i = 0; i < int'(y); i++) begin
                    lo = 8'(lo * x);
                    big = big * int'(x) > 256 ? 256 : big * int'(x);
                end
                r = lo;
                ov = big > 255;
                if (y != 0) lat = 1 + $clog2(int'(y) + 1);
            end
            default: r = x;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output int k);
        exp_t e;
        logic rdy;
        k = -1;
        op = o;
        a = x;
        b = y;
        start_valid = 1;
        for (int n = 0; n < 200 && k < 0; n++) begin
            @(negedge clk);
            rdy = start_ready;
            @(posedge clk);
            #1;
            if (rdy) k = cyc;
        end
        start_valid = 0;
        op = 3'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
        if (k < 0) chk("accept_timeout", 0, 1);
        else begin
            model(o, x, y, e.r, e.o, e.lat);
            e.k = k;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && q.size() > 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    bit pv = 0, hs = 0;
    logic [7:0] hr;
    logic ho;
    always @(negedge clk) begin
        if (rst) begin
            pv = 0;
            hs = 0;
        end else begin
            if (hs) begin
                chk("ready_after_hs", int'(start_ready), 1);
                chk("valid_drop", int'(res_valid), 0);
            end
            if (res_valid && !pv) begin
                chk("pending", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", int'(result), int'(e.r));
                    chk("overflow", int'(overflow), int'(e.o));
                    chk("latency", cyc - e.k, e.lat);
                end
                hr = result;
                ho = overflow;
            end else if (res_valid) begin
                chk("hold_result", int'(result), int'(hr));
                chk("hold_overflow", int'(overflow), int'(ho));
                chk("hold_busy", int'(busy), 1);
                chk("hold_not_ready", int'(start_ready), 0);
            end
            hs = res_valid && res_ready;
            if (hs) last_hs = cyc + 1;
            pv = res_valid;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] d_op[8] = '{3'd0, 3'd1, 3'd5, 3'd4, 3'd6, 3'd6, 3'd6, 3'd6};
    logic [7:0] d_a[8]  = '{8'd200, 8'd5, 8'd15, 8'hF0, 8'd3, 8'd2, 8'd0, 8'd16};
    logic [7:0] d_b[8]  = '{8'd100, 8'd9, 8'd17, 8'h3C, 8'd5, 8'd8, 8'd0, 8'd1};

    initial begin
        int k, k2;
        logic [2:0] o;
        logic [7:0] x, y;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", int'(result), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(start_ready), 1);
        rst = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            issue(d_op[i], d_a[i], d_b[i], k);
            drain();
        end
        issue(3'd5, 8'd12, 8'd12, k);
        repeat (3) begin
            @(posedge clk);
            #1;
            a = 8'($urandom);
            b = 8'($urandom);
        end
        drain();
        res_ready = 0;
        issue(3'd0, 8'd7, 8'd8, k);
        fork
            issue(3'd3, 8'h0F, 8'hA0, k2);
            begin
                repeat (7) @(posedge clk);
                #1;
                res_ready = 1;
            end
        join
        chk("accept_after_hs", k2, last_hs + 1);
        drain();
        issue(3'd6, 8'd3, 8'd255, k);
        repeat (4) @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("midrst_result", int'(result), 0);
        chk("midrst_overflow", int'(overflow), 0);
        chk("midrst_valid", int'(res_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(start_ready), 1);
        q.delete();
        #4;
        rst = 0;
        #1;
        chk("postrst_ready", int'(start_ready), 1);
        chk("postrst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        issue(3'd0, 8'd1, 8'd1, k);
        drain();
        rr_rand = 1;
        repeat (60) begin
            o = 3'($urandom_range(0, 7));
            x = 8'($urandom);
            y = 8'($urandom);
            if (o == 3'd6 && $urandom_range(0, 1) == 1) begin
                x = 8'($urandom_range(0, 3));
                y = 8'($urandom_range(0, 7));
            end
            issue(o, x, y, k);
        end
        rr_rand = 0;
        @(posedge clk);
        #2;
        res_ready = 1;
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
